// File: rtl/ascon_permutation_core_pkg.sv
`default_nettype none
// ============================================================================
// ascon_permutation_core_pkg : shared Ascon state, round tables and mode types
// Revision : 1.0
// ============================================================================
package ascon_permutation_core_pkg;

  typedef logic [319:0] ascon_state;
  typedef logic [3:0]   round;

  typedef enum logic [1:0] {
    P12  = 2'b00,
    P8   = 2'b01,
    P6   = 2'b10,
    RSVD = 2'b11
  } ascon_perm_mode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ascon_perm_fsm_state;

  localparam round c_idx_end = 4'd12;

  function automatic logic [7:0] const_add(input round k);
    case (k)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  // Column index is {s0, s1, s2, s3, s4}, s0 being the MSB.
  function automatic logic [4:0] s_box(input logic [4:0] x);
    case (x)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic round perm_start_idx(input ascon_perm_mode mode);
    case (mode)
      P12:     return 4'd0;
      P8:      return 4'd4;
      P6:      return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic round perm_nr(input ascon_perm_mode mode);
    case (mode)
      P12:     return 4'd12;
      P8:      return 4'd8;
      P6:      return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_permutation_core_round.sv
`default_nettype none
// ============================================================================
// ascon_round : one combinational Ascon round (constant add, S-box, linear)
// Revision : 1.0
// ============================================================================
module ascon_round
  import ascon_permutation_core_pkg::*;
(
  input  ascon_state i_state,
  input  round       i_round,
  output ascon_state o_state
);

  logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  assign w_c0 = i_state[319:256];
  assign w_c1 = i_state[255:192];
  assign w_c2 = i_state[191:128] ^ {56'h0, const_add(i_round)};
  assign w_c3 = i_state[127:64];
  assign w_c4 = i_state[63:0];

  always_comb begin
    w_s0 = '0;
    w_s1 = '0;
    w_s2 = '0;
    w_s3 = '0;
    w_s4 = '0;
    for (int j = 0; j < 64; j++) begin
      {w_s0[j], w_s1[j], w_s2[j], w_s3[j], w_s4[j]} =
        s_box({w_c0[j], w_c1[j], w_c2[j], w_c3[j], w_c4[j]});
    end
  end

  assign o_state = {w_s0 ^ ror64(w_s0, 19) ^ ror64(w_s0, 28),
                    w_s1 ^ ror64(w_s1, 61) ^ ror64(w_s1, 39),
                    w_s2 ^ ror64(w_s2,  1) ^ ror64(w_s2,  6),
                    w_s3 ^ ror64(w_s3, 10) ^ ror64(w_s3, 17),
                    w_s4 ^ ror64(w_s4,  7) ^ ror64(w_s4, 41)};

endmodule
`default_nettype wire

// File: rtl/ascon_permutation_core.sv
`default_nettype none
// ============================================================================
// ascon_permutation_core : p12/p8/p6 engine, UNROLL rounds per clock
// Revision : 1.0
// ============================================================================
module ascon_permutation_core
  import ascon_permutation_core_pkg::*;
#(
  parameter int UNROLL = 1
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_mode,
  input  ascon_state in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output ascon_state out_state,
  output logic       err,
  output logic       busy
);

  localparam round c_step = round'(UNROLL);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("ascon_permutation_core: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  ascon_perm_fsm_state r_fsm;
  ascon_state          r_state;
  round                r_idx;
  round                r_left;
  logic                r_err;

  ascon_perm_mode      w_mode;
  logic                w_illegal;
  ascon_state          w_chain [UNROLL+1];

  assign w_mode    = ascon_perm_mode'(in_mode);
  // p6 cannot be split into whole 4-round steps.
  assign w_illegal = (w_mode == RSVD) || ((w_mode == P6) && (UNROLL == 4));

  assign w_chain[0] = r_state;

  generate
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
      ascon_round u_round (
        .i_state (w_chain[i]),
        .i_round (r_idx + round'(i)),
        .o_state (w_chain[i+1])
      );
    end
  endgenerate

  // Rounds-left reaching one step coincides with the index reaching 12.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state <= in_state;
              r_idx   <= perm_start_idx(w_mode);
              r_left  <= perm_nr(w_mode);
              r_fsm   <= RUN;
            end
          end
        end
        RUN: begin
          r_state <= w_chain[UNROLL];
          r_idx   <= r_idx + c_step;
          r_left  <= r_left - c_step;
          if (r_left == c_step) begin
            r_fsm <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm == RUN) || (r_fsm == DONE);
  assign err       = r_err;
  assign out_state = r_state;

endmodule
`default_nettype wire

// File: doc/ascon_permutation_core.md
# ascon_permutation_core

Parametrised Ascon permutation engine that applies p12, p8 or p6 to a 320-bit Ascon state, with a configurable number of rounds unrolled per clock cycle. It replaces the fixed one-round-per-cycle permutation datapath. Every Ascon mode controller in the design (AEAD128, hash, XOF) uses it through a valid/ready request/response handshake.

## Interface
- UNROLL, default 1: rounds computed per clock cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: a request is present.
- in_ready, output, 1: the core accepts a request. Equals (state == IDLE).
- in_mode, input, 2: permutation select. 2'b00 = p12, 2'b01 = p8, 2'b10 = p6, 2'b11 = reserved.
- in_state, input, 320: input state of type ascon_state, with s0 at the MSBs.
- out_valid, output, 1: the result is valid. It is held until accepted.
- out_ready, input, 1: the consumer accepts the result.
- out_state, output, 320: the permuted state.
- err, output, 1: one-cycle pulse when a request is rejected.
- busy, output, 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when in_valid && in_ready && the mode is legal.
  - Load the state register with in_state.
  - Load the round index with the start index: p12 = 0, p8 = 4, p6 = 6.
  - Latch the round count: NR = 12, 8 or 6.
- Illegal requests are in_mode = 2'b11, or p6 with UNROLL = 4 (6 is not a multiple of 4).
  - The request is consumed (in_ready is 1).
  - err = 1 in the following cycle.
  - The state stays IDLE and no output is produced.
- RUN: each cycle applies UNROLL consecutive rounds, then adds UNROLL to the round index.
  - Round k uses const_add[k] as its constant, XORed into s2[7:0].
  - When the index reaches 12 after the update, go to DONE.
- DONE: out_valid = 1 and out_state = state register, held stable until out_ready.
  - out_valid && out_ready -> IDLE.
- One round is: constant add, 5-bit S-box substitution using s_box, bit-sliced across the 64 columns (column bit 4 = s0), then the linear layer.
- Linear layer rotate-right amounts: s0 (19, 28), s1 (61, 39), s2 (1, 6), s3 (10, 17), s4 (7, 41). Each word is XORed with its two rotations.
- The round index is 4 bits wide and never wraps past 12 for any legal mode/UNROLL combination.
- in_valid while busy: in_ready = 0, so there is no effect. The requester must hold in_valid and its data stable until accepted.
- out_ready while not DONE: ignored.
- Reset mid-operation (rst_n = 0 at any clock edge):
  - state -> IDLE and the round index -> 0;
  - out_valid, err and busy -> 0, and out_state -> 0;
  - any in-flight result is discarded.
- Reset values: in_ready = 1 (IDLE), out_valid = 0, out_state = 320'h0, err = 0, busy = 0.

## Timing
- Accept edge at cycle t. out_valid rises after the edge of cycle t + NR/UNROLL.
  - p12 with UNROLL = 1: 12 cycles of latency.
  - p8 with UNROLL = 2: 4 cycles.
  - p12 with UNROLL = 4: 3 cycles.
- Output handshake at edge u: in_ready = 1 from cycle u+1. The minimum request spacing is NR/UNROLL + 2 cycles.
- in_ready does not depend combinationally on any input.
- err is registered and pulses exactly one cycle after the rejecting edge.
- The critical path is UNROLL chained rounds. UNROLL = 4 is intended for relaxed clock targets only.

## Structure
- Add to the shared package:
  - typedef ascon_perm_mode, an enum with P12, P8, P6 and RSVD;
  - functions perm_start_idx(mode) and perm_nr(mode);
  - an enum ascon_perm_fsm_state with IDLE, RUN and DONE.
- Reuse the existing ascon_state, round, const_add and s_box definitions.
- Sub-module ascon_round: combinational, with inputs ascon_state and round index and output ascon_state. ascon_permutation_core instantiates it UNROLL times in a generate chain, with index k+i feeding instance i.

## Test plan
- Known answer for p12, with UNROLL in {1, 2, 4}:
  - Stimulus: in_state = {IV, K = 128'h000102…0F, N = 128'h000102…0F}, mode 2'b00.
  - Expect out_state equal to the golden-model p12 output, with out_valid exactly 12/6/3 cycles after acceptance.
- p8 and p6 on a random state with UNROLL = 2: match the golden model, with latencies of 4 and 3 cycles.
- Backpressure: hold out_ready = 0 for 10 cycles after DONE.
  - out_valid and out_state stay stable and in_ready stays 0.
  - Pulsing out_ready then gives in_ready = 1 on the next cycle.
- Illegal modes: in_mode = 2'b11, then p6 with UNROLL = 4.
  - err pulses one cycle after each, out_valid stays 0 and the FSM stays IDLE.
- Reset mid-RUN: drive rst_n = 0 for 1 cycle at round index 4.
  - All outputs return to reset values.
  - A following legal request completes correctly with normal latency.
- Back-to-back: 20 random requests with in_valid held high and random out_ready.
  - Every result matches the golden model, in order, with none dropped or duplicated.
